// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: advances one pixel per strobe and produces registered
// sync, data-enable, pixel coordinates and line/frame start pulses.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic          pix_strb_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  // state | meaning (same for h and v)
  // *_ACT | visible region
  // *_FPO | front porch
  // *_SYN | sync pulse
  // *_BPO | back porch; reset state so the first strobe wraps to (0,0)
  typedef enum logic [1:0] {H_ACT, H_FPO, H_SYN, H_BPO} h_state_e;
  typedef enum logic [1:0] {V_ACT, V_FPO, V_SYN, V_BPO} v_state_e;

  localparam logic [HW-1:0] H_FPO_AT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYN_AT = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_BPO_AT = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [VW-1:0] V_FPO_AT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYN_AT = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_BPO_AT = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ONE    = VW'(1);

  h_state_e      h_state_q, h_state_d;
  v_state_e      v_state_q, v_state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          h_wrap, v_wrap;

  always_comb begin
    h_wrap        = (h_cnt_q == H_LAST);
    v_wrap        = (v_cnt_q == V_LAST);
    h_state_d     = h_state_q;
    v_state_d     = v_state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_strb_i) begin
      h_cnt_d       = h_wrap ? '0 : h_cnt_q + H_ONE;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;

      case (h_state_q)
        H_ACT:   if (h_cnt_d == H_FPO_AT) h_state_d = H_FPO;
        H_FPO:   if (h_cnt_d == H_SYN_AT) h_state_d = H_SYN;
        H_SYN:   if (h_cnt_d == H_BPO_AT) h_state_d = H_BPO;
        H_BPO:   if (h_wrap)              h_state_d = H_ACT;
        default:                          h_state_d = H_BPO;
      endcase

      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + V_ONE;
        case (v_state_q)
          V_ACT:   if (v_cnt_d == V_FPO_AT) v_state_d = V_FPO;
          V_FPO:   if (v_cnt_d == V_SYN_AT) v_state_d = V_SYN;
          V_SYN:   if (v_cnt_d == V_BPO_AT) v_state_d = V_BPO;
          V_BPO:   if (v_wrap)              v_state_d = V_ACT;
          default:                          v_state_d = V_BPO;
        endcase
      end

      // Decode from next state so the registered outputs line up with x_o/y_o.
      de_d    = (h_state_d == H_ACT) && (v_state_d == V_ACT);
      hsync_d = (h_state_d == H_SYN) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = (v_state_d == V_SYN) ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      h_state_q     <= H_BPO;
      v_state_q     <= V_BPO;
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign x_o           = h_cnt_q;
  assign y_o           = v_cnt_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule
